// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: default sizes, opcodes,
// flag bit positions and FSM state encoding.
package alu_issue_ctrl_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_OPW   = 3;
  localparam int DEF_DEPTH = 2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  // Bit positions inside the 4-bit {Z,N,C,V} flag word.
  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command and result handshake bundle for the ALU issue controller.
// Both channels use valid/ready: a transfer happens on a rising edge where
// valid and ready are both 1; valid holds with stable data until then.
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [OPW-1:0]   cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [3:0]       res_flags;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_data, res_flags
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_data, res_flags
  );

endinterface

// File: rtl/alu_result_fifo.sv
// Small synchronous FIFO holding {result, flags} words; head is visible
// combinationally and storage resets to zero so the head reads 0 after reset.
module alu_result_fifo #(
  parameter int DW    = 12,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of a combinational ALU: latches one command, lets the
// ALU evaluate for one cycle, then queues the result with Z/N/C/V flags.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OPW   = DEF_OPW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_ctrl_if.slave  bus,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_opA,
  output logic [WIDTH-1:0] alu_opB,
  input  logic [WIDTH-1:0] alu_result,
  output state_t           state
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t           state_d;
  logic             cmd_ready;
  logic             accept;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [3:0]       flags;
  logic [WIDTH+3:0] head;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      alu_op  <= '0;
      alu_opA <= '0;
      alu_opB <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        alu_op  <= bus.cmd_op;
        alu_opA <= bus.cmd_a;
        alu_opB <= bus.cmd_b;
      end
    end
  end

  always_comb begin
    state_d   = state;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    push      = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = (fifo_count < CW'(DEPTH));
        if (bus.cmd_valid && cmd_ready) begin
          accept  = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Space was reserved on accept; the full guard is only defensive.
        push    = !fifo_full;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // a + b carries out of WIDTH bits exactly when a > (2^WIDTH - 1 - b) = ~b.
  always_comb begin
    flags        = '0;
    flags[FLG_Z] = (alu_result == '0);
    flags[FLG_N] = alu_result[WIDTH-1];
    if (alu_op == OPW'(OP_ADD)) begin
      flags[FLG_C] = (alu_opA > ~alu_opB);
      flags[FLG_V] = (alu_opA[WIDTH-1] == alu_opB[WIDTH-1]) &&
                     (alu_result[WIDTH-1] != alu_opA[WIDTH-1]);
    end
  end

  assign pop           = bus.res_valid && bus.res_ready;
  assign bus.cmd_ready = cmd_ready;
  assign bus.res_valid = !fifo_empty;
  assign bus.res_data  = head[WIDTH+3:4];
  assign bus.res_flags = head[3:0];

  alu_result_fifo #(
    .DW    (WIDTH + 4),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({alu_result, flags}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
